// File: rtl/sal_cmd_sched_pkg.sv
// Shared types and helpers for the channel command scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sal_cmd_sched_pkg;

  // DRAM command bus encoding.
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_e;

  localparam int CMD_W   = 3;
  localparam int T_W_DEF = 8;
  localparam int FAW_ACTS = 4;

  // Bank-id width for a given bank count (at least one bit).
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sal_cmd_sched_if.sv
// Request/grant and command-bus bundle between bank controllers and the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; grants are the only flow control back to the banks.
interface sal_cmd_sched_if
  import sal_cmd_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int RA_W      = 16,
  parameter int CA_W      = 10
) ();

  localparam int BW = bank_w(NUM_BANKS);
  localparam int AW = max_w(RA_W, CA_W);

  logic [NUM_BANKS-1:0]      act_req_i;
  logic [NUM_BANKS-1:0]      rd_req_i;
  logic [NUM_BANKS-1:0]      wr_req_i;
  logic [NUM_BANKS-1:0]      pre_req_i;
  logic [NUM_BANKS-1:0]      ref_req_i;
  logic [NUM_BANKS*RA_W-1:0] ra_i;
  logic [NUM_BANKS*CA_W-1:0] ca_i;

  logic [NUM_BANKS-1:0]      act_gnt_o;
  logic [NUM_BANKS-1:0]      rd_gnt_o;
  logic [NUM_BANKS-1:0]      wr_gnt_o;
  logic [NUM_BANKS-1:0]      pre_gnt_o;
  logic [NUM_BANKS-1:0]      ref_gnt_o;

  logic                      cmd_valid_o;
  logic [CMD_W-1:0]          cmd_o;
  logic [BW-1:0]             cmd_ba_o;
  logic [AW-1:0]             cmd_addr_o;

  // Bank-controller side.
  modport master (
    output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
    input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
    input  cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o
  );

  // Scheduler side.
  modport slave (
    input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
    output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
    output cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o
  );

endinterface

// File: rtl/sal_rr_arb.sv
// Round-robin picker: first set request at or after ptr, wrapping (N power of 2).
// Latency: combinational.
// Backpressure: none; caller decides whether the pick is used.
module sal_rr_arb
  import sal_cmd_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [bank_w(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [bank_w(N)-1:0] idx,
  output logic                 any
);

  localparam int BW = bank_w(N);

  logic [BW-1:0] cand;

  // Scan from the pointer upward; the bank-id width wraps the scan modulo N.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + BW'(i);
      if (!any && req[cand]) begin
        any      = 1'b1;
        idx      = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// Channel command scheduler: one grant per cycle across banks, tRRD/tCCD/tWTR/tRTW (+tFAW with SAL_TFAW_EN).
// Latency: grants combinational in the request cycle; command bus registered, valid the next cycle.
// Backpressure: ineligible or losing requests simply see no grant and must hold until granted.
module sal_cmd_sched
  import sal_cmd_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int RA_W      = 16,
  parameter int CA_W      = 10,
  parameter int T_W       = T_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  sal_cmd_sched_if.slave bus,
  input  logic [T_W-1:0] t_rrd_m1_i,
  input  logic [T_W-1:0] t_ccd_m1_i,
  input  logic [T_W-1:0] t_wtr_m1_i,
  input  logic [T_W-1:0] t_rtw_m1_i
`ifdef SAL_TFAW_EN
  ,
  input  logic [T_W-1:0] t_faw_m1_i
`endif
);

  localparam int BW = bank_w(NUM_BANKS);
  localparam int AW = max_w(RA_W, CA_W);

  logic [T_W-1:0]       rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic                 rrd_met, ccd_met, wtr_met, rtw_met, faw_ok;
  logic [NUM_BANKS-1:0] rd_elig, wr_elig, act_elig, col_req, row_req, col_gnt, row_gnt;
  logic [BW-1:0]        col_ptr, row_ptr, col_idx, row_idx, win_ba;
  logic                 col_any, row_any;
  cmd_e                 row_cmd, win_cmd;
  logic [AW-1:0]        win_addr;

  function automatic logic [T_W-1:0] cnt_next(input logic load, input logic [T_W-1:0] m1,
                                              input logic [T_W-1:0] cnt);
    if (load) return m1;
    if (cnt != '0) return cnt - T_W'(1);
    return cnt;
  endfunction

  assign rrd_met = (rrd_cnt == '0);
  assign ccd_met = (ccd_cnt == '0);
  assign wtr_met = (wtr_cnt == '0);
  assign rtw_met = (rtw_cnt == '0);

  // Mask requests by timing and pick the row class (REF > PRE > ACT) before arbitration.
  always_comb begin
    rd_elig  = bus.rd_req_i  & {NUM_BANKS{ccd_met & wtr_met}};
    wr_elig  = bus.wr_req_i  & {NUM_BANKS{ccd_met & rtw_met}};
    act_elig = bus.act_req_i & {NUM_BANKS{rrd_met & faw_ok}};
    col_req  = rd_elig | wr_elig;
    row_req  = '0;
    row_cmd  = CMD_NOP;
    if (|bus.ref_req_i) begin
      row_req = bus.ref_req_i;
      row_cmd = CMD_REF;
    end else if (|bus.pre_req_i) begin
      row_req = bus.pre_req_i;
      row_cmd = CMD_PRE;
    end else if (|act_elig) begin
      row_req = act_elig;
      row_cmd = CMD_ACT;
    end
  end

  sal_rr_arb #(.N(NUM_BANKS)) u_col_arb (
    .req (col_req), .ptr (col_ptr), .gnt (col_gnt), .idx (col_idx), .any (col_any)
  );

  sal_rr_arb #(.N(NUM_BANKS)) u_row_arb (
    .req (row_req), .ptr (row_ptr), .gnt (row_gnt), .idx (row_idx), .any (row_any)
  );

  // Column class beats row class; RD wins if a bank offers both RD and WR. No grants in reset.
  always_comb begin
    bus.act_gnt_o = '0;
    bus.rd_gnt_o  = '0;
    bus.wr_gnt_o  = '0;
    bus.pre_gnt_o = '0;
    bus.ref_gnt_o = '0;
    win_cmd       = CMD_NOP;
    win_ba        = '0;
    if (rst_n) begin
      if (col_any) begin
        win_ba = col_idx;
        if (rd_elig[col_idx]) begin
          bus.rd_gnt_o = col_gnt;
          win_cmd      = CMD_RD;
        end else begin
          bus.wr_gnt_o = col_gnt;
          win_cmd      = CMD_WR;
        end
      end else if (row_any) begin
        win_ba  = row_idx;
        win_cmd = row_cmd;
        case (row_cmd)
          CMD_REF: bus.ref_gnt_o = row_gnt;
          CMD_PRE: bus.pre_gnt_o = row_gnt;
          default: bus.act_gnt_o = row_gnt;
        endcase
      end
    end
  end

  // Address for the bus: row address on ACT, column address on RD/WR, zero otherwise.
  always_comb begin
    win_addr = '0;
    case (win_cmd)
      CMD_ACT:        win_addr = AW'(bus.ra_i[win_ba*RA_W +: RA_W]);
      CMD_RD, CMD_WR: win_addr = AW'(bus.ca_i[win_ba*CA_W +: CA_W]);
      default:        win_addr = '0;
    endcase
  end

  // Inter-bank timing counters: load on the relevant issue, else count down to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      wtr_cnt <= '0;
      rtw_cnt <= '0;
    end else begin
      rrd_cnt <= cnt_next(win_cmd == CMD_ACT, t_rrd_m1_i, rrd_cnt);
      ccd_cnt <= cnt_next(win_cmd == CMD_RD || win_cmd == CMD_WR, t_ccd_m1_i, ccd_cnt);
      wtr_cnt <= cnt_next(win_cmd == CMD_WR, t_wtr_m1_i, wtr_cnt);
      rtw_cnt <= cnt_next(win_cmd == CMD_RD, t_rtw_m1_i, rtw_cnt);
    end
  end

`ifdef SAL_TFAW_EN
  logic [T_W-1:0] faw_cnt [FAW_ACTS];
  logic [1:0]     faw_slot;

  // ACT allowed while any window slot is idle; the lowest idle slot takes the next ACT.
  always_comb begin
    faw_ok   = 1'b0;
    faw_slot = '0;
    for (int i = FAW_ACTS - 1; i >= 0; i--) begin
      if (faw_cnt[i] == '0) begin
        faw_ok   = 1'b1;
        faw_slot = 2'(i);
      end
    end
  end

  // Four-activate window: each slot counts down from tFAW-1 after the ACT it recorded.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FAW_ACTS; i++) begin
      if (!rst_n) faw_cnt[i] <= '0;
      else faw_cnt[i] <= cnt_next(win_cmd == CMD_ACT && faw_slot == 2'(i), t_faw_m1_i, faw_cnt[i]);
    end
  end
`else
  assign faw_ok = 1'b1;
`endif

  // Round-robin pointers move past the winner only when their own class wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_ptr <= '0;
      row_ptr <= '0;
    end else if (win_cmd == CMD_RD || win_cmd == CMD_WR) begin
      col_ptr <= col_idx + BW'(1);
    end else if (win_cmd != CMD_NOP) begin
      row_ptr <= row_idx + BW'(1);
    end
  end

  // Registered command bus toward the PHY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cmd_valid_o <= 1'b0;
      bus.cmd_o       <= '0;
      bus.cmd_ba_o    <= '0;
      bus.cmd_addr_o  <= '0;
    end else begin
      bus.cmd_valid_o <= (win_cmd != CMD_NOP);
      bus.cmd_o       <= win_cmd;
      bus.cmd_ba_o    <= win_ba;
      bus.cmd_addr_o  <= win_addr;
    end
  end

endmodule
